// File: rtl/exp_sum_buffer.sv
// Softmax denominator stage: captures one vector of e^-x samples, accumulates their sum,
// pulses the sum once, then replays the stored samples to the divider under valid/ready.
module exp_sum_buffer #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned SUM_W     = DATA_SIZE + ADDR_W
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic [ADDR_W:0]      vector_len_i,
   input  logic                 lut_data_valid_i,
   input  logic [DATA_SIZE-1:0] lut_data_i,
   input  logic                 div_ready_i,
   output logic                 busy_o,
   output logic [SUM_W-1:0]     sum_o,
   output logic                 sum_valid_o,
   output logic [DATA_SIZE-1:0] exp_data_o,
   output logic                 exp_valid_o,
   output logic                 exp_last_o,
   output logic                 error_o
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE,
      REPLAY
   } state_t;

   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W+1)'(DEPTH);

   state_t               state;
   logic [ADDR_W:0]      len;
   logic [ADDR_W:0]      len_m1;
   logic [ADDR_W:0]      wr_cnt;
   logic [ADDR_W:0]      rd_cnt;
   logic                 len_ok;
   logic [DATA_SIZE-1:0] mem [DEPTH];

   assign len_m1 = len - CNT_ONE;
   assign len_ok = (vector_len_i != '0) && (vector_len_i <= DEPTH_LEN);

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state   <= IDLE;
         len     <= '0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
         sum_o   <= '0;
         error_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i && len_ok) begin
                  len    <= vector_len_i;
                  sum_o  <= '0;
                  wr_cnt <= '0;
                  // a sample arriving alongside the start is dropped, so the clear loses to it
                  error_o <= lut_data_valid_i;
                  state  <= ACCUM;
               end else if (start_i || lut_data_valid_i) begin
                  error_o <= 1'b1;
               end
            end
            ACCUM: begin
               if (start_i) error_o <= 1'b1;
               if (lut_data_valid_i) begin
                  sum_o  <= sum_o + SUM_W'(lut_data_i);
                  wr_cnt <= wr_cnt + CNT_ONE;
                  if (wr_cnt == len_m1) state <= DONE;
               end
            end
            DONE: begin
               if (start_i || lut_data_valid_i) error_o <= 1'b1;
               rd_cnt <= '0;
               state  <= REPLAY;
            end
            REPLAY: begin
               if (start_i || lut_data_valid_i) error_o <= 1'b1;
               if (div_ready_i) begin
                  rd_cnt <= rd_cnt + CNT_ONE;
                  if (rd_cnt == len_m1) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock_i) begin
      if (state == ACCUM && lut_data_valid_i)
         mem[wr_cnt[ADDR_W-1:0]] <= lut_data_i;
   end

   assign busy_o      = (state != IDLE);
   assign sum_valid_o = (state == DONE);
   assign exp_valid_o = (state == REPLAY);
   assign exp_last_o  = (state == REPLAY) && (rd_cnt == len_m1);
   assign exp_data_o  = (state == REPLAY) ? mem[rd_cnt[ADDR_W-1:0]] : '0;

endmodule

// File: tb/tb_exp_sum_buffer.sv
// Directed self-checking bench for exp_sum_buffer: accumulation, replay handshake,
// protocol-error flag and asynchronous reset.
module tb_exp_sum_buffer;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [4:0]  vec_len;
   logic        lut_valid;
   logic [31:0] lut_data;
   logic        div_ready;
   logic        busy;
   logic [35:0] sum;
   logic        sum_valid;
   logic [31:0] exp_data;
   logic        exp_valid;
   logic        exp_last;
   logic        error;

   int unsigned total;
   int unsigned bad;
   logic [31:0] ev [16];

   exp_sum_buffer #(
      .DATA_SIZE (32),
      .DEPTH     (16),
      .ADDR_W    (4),
      .SUM_W     (36)
   ) dut (
      .clock_i          (clk),
      .reset_n_i        (rst_n),
      .start_i          (start),
      .vector_len_i     (vec_len),
      .lut_data_valid_i (lut_valid),
      .lut_data_i       (lut_data),
      .div_ready_i      (div_ready),
      .busy_o           (busy),
      .sum_o            (sum),
      .sum_valid_o      (sum_valid),
      .exp_data_o       (exp_data),
      .exp_valid_o      (exp_valid),
      .exp_last_o       (exp_last),
      .error_o          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_vec(input logic [4:0] n);
      start   = 1'b1;
      vec_len = n;
      tick();
      start   = 1'b0;
   endtask

   task automatic feed(input logic [31:0] d);
      lut_valid = 1'b1;
      lut_data  = d;
      tick();
      lut_valid = 1'b0;
   endtask

   // expects to be called with the DUT in REPLAY and div_ready held high
   task automatic drain(input string tag, input int unsigned n);
      div_ready = 1'b1;
      for (int unsigned i = 0; i < n; i++) begin
         check({tag, "_valid"}, 64'(exp_valid), 64'd1);
         check({tag, "_data"},  64'(exp_data),  64'(ev[i]));
         check({tag, "_last"},  64'(exp_last),  64'(i == n - 1));
         tick();
      end
      check({tag, "_end_valid"}, 64'(exp_valid), 64'd0);
      check({tag, "_end_busy"},  64'(busy),      64'd0);
   endtask

   initial begin
      logic [15:0] pat;
      int unsigned idx;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      start     = 1'b0;
      vec_len   = '0;
      lut_valid = 1'b0;
      lut_data  = '0;
      div_ready = 1'b1;
      #3;
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_sum",       64'(sum),       64'd0);
      check("rst_sum_valid", 64'(sum_valid), 64'd0);
      check("rst_exp_valid", 64'(exp_valid), 64'd0);
      check("rst_exp_data",  64'(exp_data),  64'd0);
      check("rst_error",     64'(error),     64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // basic 4-element vector
      start_vec(5'd4);
      check("t1_busy", 64'(busy), 64'd1);
      ev[0] = 32'hFFFF_FFFF; ev[1] = 32'h8000_0000; ev[2] = 32'h4000_0000; ev[3] = 32'h0000_0001;
      for (int unsigned i = 0; i < 4; i++) begin
         check("t1_no_sum_valid", 64'(sum_valid), 64'd0);
         feed(ev[i]);
      end
      check("t1_sum_valid", 64'(sum_valid), 64'd1);
      check("t1_sum",       64'(sum),       64'h1_C000_0000);
      tick();
      check("t1_sum_pulse", 64'(sum_valid), 64'd0);
      drain("t1", 4);
      check("t1_sum_hold", 64'(sum),   64'h1_C000_0000);
      check("t1_error",    64'(error), 64'd0);

      // full depth with gaps
      start_vec(5'd16);
      for (int unsigned i = 0; i < 16; i++) begin
         ev[i] = 32'hFFFF_FFFF;
         repeat ($urandom_range(0, 3)) tick();
         feed(ev[i]);
      end
      check("t2_sum_valid", 64'(sum_valid), 64'd1);
      check("t2_sum",       64'(sum),       64'hF_FFFF_FFF0);
      check("t2_error",     64'(error),     64'd0);
      tick();
      drain("t2", 16);

      // replay under backpressure
      start_vec(5'd3);
      ev[0] = 32'h1111_1111; ev[1] = 32'h2222_2222; ev[2] = 32'h3333_3333;
      for (int unsigned i = 0; i < 3; i++) feed(ev[i]);
      check("t3_sum", 64'(sum), 64'h0_6666_6666);
      div_ready = 1'b0;
      tick();
      pat = 16'b1011_0010_0110_0100;
      idx = 0;
      for (int unsigned c = 0; c < 48 && idx < 3; c++) begin
         div_ready = pat[c % 16];
         check("t3_valid", 64'(exp_valid), 64'd1);
         check("t3_data",  64'(exp_data),  64'(ev[idx]));
         check("t3_last",  64'(exp_last),  64'(idx == 2));
         if (div_ready) idx++;
         tick();
      end
      check("t3_xfers",     64'(idx),       64'd3);
      check("t3_end_valid", 64'(exp_valid), 64'd0);
      check("t3_end_busy",  64'(busy),      64'd0);
      div_ready = 1'b1;

      // illegal lengths and stray samples
      start_vec(5'd0);
      check("t4_len0_busy",  64'(busy),  64'd0);
      check("t4_len0_error", 64'(error), 64'd1);
      start_vec(5'd17);
      check("t4_len17_busy",  64'(busy),  64'd0);
      check("t4_len17_error", 64'(error), 64'd1);
      start_vec(5'd1);
      check("t4_clear_error", 64'(error), 64'd0);
      check("t4_busy",        64'(busy),  64'd1);
      ev[0] = 32'h0000_0005;
      feed(ev[0]);
      check("t4_sum", 64'(sum), 64'h0_0000_0005);
      tick();
      drain("t4", 1);
      feed(32'hABCD_0000);
      check("t4_idle_valid_error", 64'(error), 64'd1);
      check("t4_idle_valid_busy",  64'(busy),  64'd0);
      check("t4_idle_valid_sum",   64'(sum),   64'h0_0000_0005);

      // start pulse mid-accumulation is ignored
      start_vec(5'd4);
      check("t5_clear_error", 64'(error), 64'd0);
      ev[0] = 32'h0000_0001; ev[1] = 32'h0000_0002; ev[2] = 32'h0000_0003; ev[3] = 32'h0000_0004;
      feed(ev[0]);
      feed(ev[1]);
      start_vec(5'd2);
      check("t5_start_error", 64'(error), 64'd1);
      check("t5_start_busy",  64'(busy),  64'd1);
      feed(ev[2]);
      check("t5_not_done", 64'(sum_valid), 64'd0);
      feed(ev[3]);
      check("t5_sum_valid", 64'(sum_valid), 64'd1);
      check("t5_sum",       64'(sum),       64'h0_0000_000A);
      tick();
      drain("t5", 4);

      // asynchronous reset mid-accumulation
      start_vec(5'd4);
      feed(32'h7000_0000);
      feed(32'h7000_0000);
      check("t6_pre_sum", 64'(sum), 64'h0_E000_0000);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_busy",  64'(busy),      64'd0);
      check("t6_rst_sum",   64'(sum),       64'd0);
      check("t6_rst_error", 64'(error),     64'd0);
      check("t6_rst_sv",    64'(sum_valid), 64'd0);
      check("t6_rst_ev",    64'(exp_valid), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      // start and a stray sample together: start wins, sample dropped, error left set
      lut_valid = 1'b1;
      lut_data  = 32'hDEAD_BEEF;
      start_vec(5'd1);
      lut_valid = 1'b0;
      check("t6_both_busy",  64'(busy),  64'd1);
      check("t6_both_error", 64'(error), 64'd1);
      ev[0] = 32'h1234_5678;
      feed(ev[0]);
      check("t6_sum_valid", 64'(sum_valid), 64'd1);
      check("t6_sum",       64'(sum),       64'h0_1234_5678);
      tick();
      drain("t6", 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
